// File: rtl/uart_pkg.sv
// Constants and helpers shared by the UART receiver, transmitter and their FIFOs.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  // 100 MHz system clock over 115200 baud.
  localparam int UART_BAUD_TICK_DEFAULT = 868;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int uart_level_w(input int depth);
    if (depth <= 1) return 1;
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
// Shared between the RX and TX FIFOs.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO behind the UART receiver, with sticky overrun.
// Optional threshold interrupt enabled by defining UART_RX_FIFO_THRESH_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = 16,
  parameter int THRESH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_W-1:0]                in_data,
  input  logic                             in_valid,
  output logic [DATA_W-1:0]                out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [uart_level_w(DEPTH)-1:0]   level,
  output logic                             overrun,
  input  logic                             clr_overrun,
`ifdef UART_RX_FIFO_THRESH_EN
  output logic                             thresh_irq,
`endif
  input  logic                             flush
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = uart_level_w(DEPTH);

  logic [AW-1:0]     rd_ptr_reg, rd_ptr_next, wr_ptr_reg, wr_ptr_next;
  logic [LW-1:0]     level_reg, level_next;
  logic [DATA_W-1:0] out_data_reg, out_data_next, mem_rd_data;
  logic              overrun_reg, overrun_next;
  logic              full, empty, pop, push, drop, wr_en;

  assign full  = (level_reg == LW'(DEPTH));
  assign empty = (level_reg == '0);
  assign pop   = !empty && out_ready;
  assign push  = in_valid && (!full || pop);
  assign drop  = in_valid && full && !pop;

  // The read port looks at the post-edge head so out_data can be registered.
  uart_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_reg),
    .wr_data (in_data),
    .rd_addr (rd_ptr_next),
    .rd_data (mem_rd_data)
  );

  always_comb begin
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    level_next    = level_reg;
    wr_en         = 1'b0;
    out_data_next = out_data_reg;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      level_next  = '0;
    end else begin
      wr_en = push;
      if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
      if (push && !pop)      level_next = level_reg + LW'(1);
      else if (pop && !push) level_next = level_reg - LW'(1);
    end
    // Head slot being written this edge is not yet in the array: forward it.
    if (level_next != '0)
      out_data_next = (wr_en && (wr_ptr_reg == rd_ptr_next)) ? in_data : mem_rd_data;
    if (drop && !flush)   overrun_next = 1'b1;
    else if (clr_overrun) overrun_next = 1'b0;
    else                  overrun_next = overrun_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      level_reg    <= '0;
      out_data_reg <= '0;
      overrun_reg  <= 1'b0;
    end else begin
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      level_reg    <= level_next;
      out_data_reg <= out_data_next;
      overrun_reg  <= overrun_next;
    end
  end

`ifdef UART_RX_FIFO_THRESH_EN
  logic thresh_irq_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) thresh_irq_reg <= 1'b0;
    else                 thresh_irq_reg <= (level_reg >= LW'(THRESH));
  end

  assign thresh_irq = thresh_irq_reg;
`endif

  assign out_data  = out_data_reg;
  assign out_valid = !empty;
  assign level     = level_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, THRESH=8).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] level;
  logic       overrun;
  logic       clr_overrun;
  logic       flush;
`ifdef UART_RX_FIFO_THRESH_EN
  logic       thresh_irq;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_W(8), .DEPTH(16), .THRESH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .level       (level),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
`ifdef UART_RX_FIFO_THRESH_EN
    .thresh_irq  (thresh_irq),
`endif
    .flush       (flush)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Outputs are sampled 1 ns after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int rx_idx;
    int max_level;
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    clr_overrun = 1'b0; flush = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_level", level, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_overrun", overrun, 0);
`ifdef UART_RX_FIFO_THRESH_EN
    check("rst_thresh", thresh_irq, 0);
`endif

    // 1: single byte latency and pop
    push_byte(8'hA5);
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 8'hA5);
    check("t1_level", level, 1);
    pop_one();
    check("t1_pop_level", level, 0);
    check("t1_pop_valid", out_valid, 0);
    check("t1_hold_data", out_data, 8'hA5);
    pop_one();
    check("t1_ready_empty", level, 0);

    // 2: fill, overflow drop, drain in order
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check("t2_full_level", level, 16);
    check("t2_head", out_data, 8'h00);
    push_byte(8'h10);
    check("t2_overrun", overrun, 1);
    check("t2_level_drop", level, 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t2_drain%0d", i), out_data, i);
      pop_one();
    end
    check("t2_empty", level, 0);
    check("t2_overrun_sticky", overrun, 1);
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    check("t2_clr", overrun, 0);

    // 3: push and pop together while full
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    in_valid = 1'b1; in_data = 8'h30; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("t3_level", level, 16);
    check("t3_overrun", overrun, 0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t3_drain%0d", i), out_data, 8'h21 + 8'(i));
      pop_one();
    end
    check("t3_empty", level, 0);

    // 4: trickle stream with continuous ready
    out_ready = 1'b1; rx_idx = 0; max_level = 0;
    for (int i = 0; i < 40; i++) begin
      in_data = 8'h40 + 8'(i); in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
        tick();
        in_valid = 1'b0;
        if (int'(level) > max_level) max_level = int'(level);
        if (out_valid) begin
          check($sformatf("t4_rx%0d", rx_idx), out_data, 8'h40 + 8'(rx_idx));
          rx_idx++;
        end
      end
    end
    out_ready = 1'b0;
    check("t4_count", rx_idx, 40);
    check("t4_max_level", max_level, 1);

    // 5: flush behaviour and overrun priority
    for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i));
    push_byte(8'hEE);
    for (int i = 0; i < 11; i++) pop_one();
    check("t5_level5", level, 5);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("t5_flush_level", level, 0);
    check("t5_flush_valid", out_valid, 0);
    check("t5_flush_overrun", overrun, 1);
    check("t5_flush_hold", out_data, 8'h8B);
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    check("t5_clr", overrun, 0);
    for (int i = 0; i < 16; i++) push_byte(8'h90 + 8'(i));
    flush = 1'b1; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("t5_flush_full_ovr", overrun, 0);
    check("t5_flush_full_lvl", level, 0);
    for (int i = 0; i < 16; i++) push_byte(8'hB0 + 8'(i));
    in_valid = 1'b1; clr_overrun = 1'b1;
    tick();
    in_valid = 1'b0; clr_overrun = 1'b0;
    check("t5_set_beats_clr", overrun, 1);
    check("t5_level_full", level, 16);
    check("t5_head", out_data, 8'hB0);
    flush = 1'b1; tick(); flush = 1'b0;

`ifdef UART_RX_FIFO_THRESH_EN
    // 6: threshold interrupt
    for (int i = 0; i < 8; i++) push_byte(8'(i));
    check("t6_level8", level, 8);
    check("t6_irq_lag", thresh_irq, 0);
    tick();
    check("t6_irq_set", thresh_irq, 1);
    pop_one();
    check("t6_irq_lag_clr", thresh_irq, 1);
    tick();
    check("t6_irq_clr", thresh_irq, 0);
`else
    for (int i = 0; i < 8; i++) push_byte(8'(i));
`endif

    // Reset mid-stream with strobes active
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hCC; out_ready = 1'b1;
    tick();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    check("mrst_level", level, 0);
    check("mrst_valid", out_valid, 0);
    check("mrst_data", out_data, 0);
    check("mrst_overrun", overrun, 0);
`ifdef UART_RX_FIFO_THRESH_EN
    check("mrst_thresh", thresh_irq, 0);
`endif
    push_byte(8'h5A);
    check("post_rst_data", out_data, 8'h5A);
    check("post_rst_level", level, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
